systolic_serdes: RTL
====================

# systolic_serdes

Parametrised nibble-serial link endpoint for the systolic array tile. Each cycle it accepts one DIG_W-bit digit and one control bit per lane and assembles BEATS beats into a parallel frame for the compute core. It also shifts out a transmit frame on every lane. That frame is either a core-loaded result or, by default, the previous received frame passed through. It generalises the fixed two-lane, 4-bit, 16-beat column/row buffers with lane count, digit width, block length, clock enable, load handshake and optional parity.

## Interface
- LANES, 2, number of independent serial lanes (lane 0 = row, lane 1 = column in the tile).
- DIG_W, 4, digit width per lane per beat.
- BEATS, 16, beats per frame; must be ≥ 2. BW = $clog2(BEATS).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  beat enable; when low, all state holds.
- lane_din  in  LANES*DIG_W  digit in; lane l at [l*DIG_W +: DIG_W].
- lane_cin  in  LANES  control bit in, one per lane.
- lane_dout  out  LANES*DIG_W  registered digit out.
- lane_cout  out  LANES  registered control out.
- beat  out  BW  current beat index.
- frame_rx  out  LANES*BEATS*DIG_W  last complete frame; lane l, slot s at [(l*BEATS+s)*DIG_W +: DIG_W].
- frame_rx_ctrl  out  LANES*BEATS  control bits; lane l, slot s at bit l*BEATS+s.
- frame_rx_valid  out  1  one-cycle pulse: frame_rx updated.
- tx_load  in  1  load tx_frame/tx_ctrl for the next block.
- tx_frame  in  LANES*BEATS*DIG_W  same packing as frame_rx.
- tx_ctrl  in  LANES*BEATS  same packing as frame_rx_ctrl.
- tx_ovf  out  1  one-cycle pulse: a pending load was overwritten.
- rx_parity_err  out  LANES  parity mismatch per lane, valid with frame_rx_valid. Present only with parity enabled, else 0.

## Operation
- Beat counter runs 0..BEATS-1 and wraps to 0. It advances only on en cycles.
- Receive: on an en cycle at beat s, lane_din and lane_cin are written into working slot s.
- Frame boundary (en and beat==BEATS-1):
  - frame_rx/frame_rx_ctrl are loaded with the working buffer, using the current-cycle inputs for slot BEATS-1.
  - frame_rx_valid pulses on the following cycle.
- Transmit pending register:
  - tx_load captures tx_frame/tx_ctrl into the pending register on any cycle, independent of en, and sets pend_v.
  - tx_load while pend_v=1 overwrites the pending data and pulses tx_ovf on the next cycle.
- Transmit buffer at the frame boundary:
  - tx_buf is loaded with the pending frame if pend_v=1, otherwise with the just-received frame (pass-through).
  - pend_v is cleared.
  - If tx_load arrives on the boundary cycle itself, that data is used directly. pend_v stays clear and tx_ovf does not pulse unless pend_v was already set.
- Output: on every en cycle, lane_dout/lane_cout are loaded with tx_buf slot beat.
- Reset: counter, working buffer, frame_rx, frame_rx_ctrl, tx_buf, pending register, pend_v and all outputs are set to 0.
- Reset mid-block discards the partial frame and any pending load; beat 0 follows.

## Timing
- A digit entering at beat s of block n is visible on frame_rx 1 cycle after the block-n boundary. frame_rx_valid is high in that same cycle.
- In pass-through, that digit appears on lane_dout in the cycle after beat s of block n+1: BEATS+1 enabled cycles of latency.
- A loaded frame's slot s appears on lane_dout the cycle after beat s of the first block following the boundary at which it was taken.
- en low for k cycles stretches all latencies by k. frame_rx_valid fires only on the cycle after an enabled boundary.
- After reset, outputs stay 0 through the whole first block, because tx_buf was reset to 0.

## Configuration
- Macro: SYSTOLIC_SERDES_PARITY_EN.
- Defined, receive side:
  - The control bit at slot BEATS-1 of each lane carries even parity over all of that lane's BEATS*DIG_W data bits.
  - rx_parity_err[l] is 1 with frame_rx_valid when lane l's parity mismatches.
- Defined, transmit side: when tx_buf is loaded, the slot BEATS-1 control bit of each lane is replaced with the computed parity of that lane's data.
- Undefined: rx_parity_err is tied to 0 and control bits pass through unchanged.

## Test plan
- Reset, en=1 for 20 cycles, inputs 0 → all outputs 0; frame_rx_valid pulses exactly once, 16 cycles after reset release.
- Defaults, lane0 digit = beat index, lane1 = 15-beat → frame_rx lane0 slot s = s, lane1 slot s = 15-s. Next block: lane_dout lane0 = s one cycle after beat s.
- Load during beat 5 with all slots 0xA → the next block outputs 0xA on every beat; the following block reverts to pass-through.
- Two tx_load pulses in one block (0x3, then 0xC) → tx_ovf pulses once and 0xC is transmitted. Also: load exactly at beat 15 → used in the next block, no tx_ovf.
- en toggling 1-0 alternately over a block → frame completes after 32 cycles, contents identical to the continuous case. Reset asserted at beat 9 → beat returns to 0, no frame_rx_valid, lane outputs 0.
- With SYSTOLIC_SERDES_PARITY_EN, lane0 data has an odd number of ones and slot-15 ctrl=0 → rx_parity_err[0]=1 and rx_parity_err[1]=0. Pass-through output of slot 15 has its ctrl bit corrected to 1.

Source files
------------

// File: rtl/systolic_serdes.sv
// systolic_serdes: nibble-serial link endpoint for the systolic array tile.
// Each enabled beat captures one digit plus control bit per lane into a working
// frame; at the last beat the frame is published on frame_rx and a transmit
// frame (core-loaded result or the received frame passed through) is latched
// into tx_buf, which is then shifted out one slot per enabled beat.
// Optional feature macro: SYSTOLIC_SERDES_PARITY_EN (per-lane even parity
// carried in the slot BEATS-1 control bit, checked on receive, inserted on
// transmit).
module systolic_serdes #(
  parameter int unsigned LANES = 2,
  parameter int unsigned DIG_W = 4,
  parameter int unsigned BEATS = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [LANES*DIG_W-1:0]         lane_din,
  input  logic [LANES-1:0]               lane_cin,
  output logic [LANES*DIG_W-1:0]         lane_dout,
  output logic [LANES-1:0]               lane_cout,
  output logic [$clog2(BEATS)-1:0]       beat,
  output logic [LANES*BEATS*DIG_W-1:0]   frame_rx,
  output logic [LANES*BEATS-1:0]         frame_rx_ctrl,
  output logic                           frame_rx_valid,
  input  logic                           tx_load,
  input  logic [LANES*BEATS*DIG_W-1:0]   tx_frame,
  input  logic [LANES*BEATS-1:0]         tx_ctrl,
  output logic                           tx_ovf,
  output logic [LANES-1:0]               rx_parity_err
);

  localparam int unsigned BW = $clog2(BEATS);
  localparam int unsigned FW = LANES * BEATS * DIG_W;
  localparam int unsigned CW = LANES * BEATS;
  localparam int unsigned LW = BEATS * DIG_W;
  localparam logic [BW-1:0] LastBeat = BW'(BEATS - 1);

  // Beat counter and boundary detect
  logic [BW-1:0]          beat_q, beat_d;
  logic [31:0]            beat_idx;
  logic                   boundary;

  // Receive working buffer and published frame
  logic [FW-1:0]          work_q, work_d;
  logic [CW-1:0]          work_c_q, work_c_d;
  logic [FW-1:0]          frame_q, frame_d;
  logic [CW-1:0]          frame_c_q, frame_c_d;
  logic                   valid_q, valid_d;

  // Transmit pending register and transmit buffer
  logic [FW-1:0]          pend_q, pend_d;
  logic [CW-1:0]          pend_c_q, pend_c_d;
  logic                   pend_v_q, pend_v_d;
  logic                   ovf_q, ovf_d;
  logic [FW-1:0]          tx_src;
  logic [CW-1:0]          tx_src_c;
  logic [FW-1:0]          txb_q, txb_d;
  logic [CW-1:0]          txb_c_q, txb_c_d;

  // Serial outputs
  logic [LANES*DIG_W-1:0] dout_q, dout_d;
  logic [LANES-1:0]       cout_q, cout_d;

  assign beat_idx = 32'(beat_q);

  // Beat counter advances only on enabled cycles and wraps at the last beat
  always_comb begin
    boundary = en && (beat_q == LastBeat);
    beat_d   = beat_q;
    if (en) begin
      beat_d = boundary ? '0 : beat_q + BW'(1);
    end
  end

  // Working buffer with the current beat's inputs merged into slot beat
  always_comb begin
    work_d   = work_q;
    work_c_d = work_c_q;
    if (en) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        work_d[(l*BEATS + beat_idx)*DIG_W +: DIG_W] = lane_din[l*DIG_W +: DIG_W];
        work_c_d[l*BEATS + beat_idx]                = lane_cin[l];
      end
    end
  end

  // Published frame: work_d already holds the last slot from this cycle's inputs
  always_comb begin
    frame_d   = frame_q;
    frame_c_d = frame_c_q;
    valid_d   = boundary;
    if (boundary) begin
      frame_d   = work_d;
      frame_c_d = work_c_d;
    end
  end

  // Transmit source: same-cycle load wins, then a pending load, else pass-through
  always_comb begin
    if (tx_load) begin
      tx_src   = tx_frame;
      tx_src_c = tx_ctrl;
    end else if (pend_v_q) begin
      tx_src   = pend_q;
      tx_src_c = pend_c_q;
    end else begin
      tx_src   = work_d;
      tx_src_c = work_c_d;
    end
`ifdef SYSTOLIC_SERDES_PARITY_EN
    // Last-slot control bit carries even parity over the lane's data bits
    for (int unsigned l = 0; l < LANES; l++) begin
      tx_src_c[l*BEATS + BEATS - 1] = ^tx_src[l*LW +: LW];
    end
`endif
  end

  // Transmit buffer reload at the boundary
  always_comb begin
    txb_d   = txb_q;
    txb_c_d = txb_c_q;
    if (boundary) begin
      txb_d   = tx_src;
      txb_c_d = tx_src_c;
    end
  end

  // Pending register: captured on any tx_load, consumed at the boundary
  always_comb begin
    pend_d   = pend_q;
    pend_c_d = pend_c_q;
    pend_v_d = pend_v_q;
    ovf_d    = tx_load && pend_v_q;
    if (boundary) begin
      // A load on the boundary cycle itself is consumed directly
      pend_v_d = 1'b0;
    end else if (tx_load) begin
      pend_d   = tx_frame;
      pend_c_d = tx_ctrl;
      pend_v_d = 1'b1;
    end
  end

  // Serial output: present tx_buf slot beat on each enabled cycle
  always_comb begin
    dout_d = dout_q;
    cout_d = cout_q;
    if (en) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        dout_d[l*DIG_W +: DIG_W] = txb_q[(l*BEATS + beat_idx)*DIG_W +: DIG_W];
        cout_d[l]                = txb_c_q[l*BEATS + beat_idx];
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q    <= '0;
      work_q    <= '0;
      work_c_q  <= '0;
      frame_q   <= '0;
      frame_c_q <= '0;
      valid_q   <= 1'b0;
      pend_q    <= '0;
      pend_c_q  <= '0;
      pend_v_q  <= 1'b0;
      ovf_q     <= 1'b0;
      txb_q     <= '0;
      txb_c_q   <= '0;
      dout_q    <= '0;
      cout_q    <= '0;
    end else begin
      beat_q    <= beat_d;
      work_q    <= work_d;
      work_c_q  <= work_c_d;
      frame_q   <= frame_d;
      frame_c_q <= frame_c_d;
      valid_q   <= valid_d;
      pend_q    <= pend_d;
      pend_c_q  <= pend_c_d;
      pend_v_q  <= pend_v_d;
      ovf_q     <= ovf_d;
      txb_q     <= txb_d;
      txb_c_q   <= txb_c_d;
      dout_q    <= dout_d;
      cout_q    <= cout_d;
    end
  end

`ifdef SYSTOLIC_SERDES_PARITY_EN
  logic [LANES-1:0] perr_q, perr_d;

  // Receive parity check on the frame being published; cleared otherwise
  always_comb begin
    perr_d = '0;
    if (boundary) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        perr_d[l] = (^work_d[l*LW +: LW]) ^ work_c_d[l*BEATS + BEATS - 1];
      end
    end
  end

  // Parity error register, valid alongside frame_rx_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q <= '0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign rx_parity_err = perr_q;
`else
  assign rx_parity_err = '0;
`endif

  assign lane_dout      = dout_q;
  assign lane_cout      = cout_q;
  assign beat           = beat_q;
  assign frame_rx       = frame_q;
  assign frame_rx_ctrl  = frame_c_q;
  assign frame_rx_valid = valid_q;
  assign tx_ovf         = ovf_q;

endmodule
